// File: rtl/guess_pkg.sv
// Types shared by the guess-capture and sequence-player blocks.
package guess_pkg;
   localparam int STEPS_DEFAULT = 7;

   typedef enum logic [1:0] {IDLE, ON, OFF, DONE} player_state_t;

   typedef logic [0:STEPS_DEFAULT-1] code_t;
endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one ON or OFF phase; expire is high in the phase's last cycle.
module phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] len,
   output logic         expire
);

   logic [W-1:0] cnt;

   // Loading len-1 makes a phase of len cycles end on the cycle where cnt reads 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= len - 1'b1;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/sequence_player.sv
// Replays four latched step codes as timed pulses on O1..O4.
// Optional feature: SEQ_PLAYER_SKIP_EMPTY_EN collapses all-zero steps to a single ON cycle.
module sequence_player
   import guess_pkg::*;
#(
   parameter int STEPS      = STEPS_DEFAULT,
   parameter int ON_CYCLES  = 2,
   parameter int OFF_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [0:STEPS-1]         A,
   input  logic [0:STEPS-1]         B,
   input  logic [0:STEPS-1]         C,
   input  logic [0:STEPS-1]         D,
   output logic                     O1,
   output logic                     O2,
   output logic                     O3,
   output logic                     O4,
   output logic [$clog2(STEPS)-1:0] step,
   output logic                     busy,
   output logic                     done
);

   localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int SW   = $clog2(STEPS);
   localparam logic [CW-1:0] ON_LEN  = CW'(ON_CYCLES);
   localparam logic [CW-1:0] OFF_LEN = CW'(OFF_CYCLES);

   player_state_t    state;
   logic [0:STEPS-1] sh_a, sh_b, sh_c, sh_d;
   logic [SW-1:0]    idx, nxt;
   logic             last, skip_now;
   logic             tmr_load, tmr_expire;
   logic [CW-1:0]    tmr_len;

   assign nxt  = idx + 1'b1;
   assign last = (idx == SW'(STEPS - 1));
   assign step = idx;

`ifdef SEQ_PLAYER_SKIP_EMPTY_EN
   assign skip_now = ~(sh_a[idx] | sh_b[idx] | sh_c[idx] | sh_d[idx]);
`else
   assign skip_now = 1'b0;
`endif

   phase_timer #(.W(CW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .len    (tmr_len),
      .expire (tmr_expire)
   );

   // Timer reloads coincide with every entry into ON or OFF.
   always_comb begin
      tmr_load = 1'b0;
      tmr_len  = ON_LEN;
      unique case (state)
         IDLE: tmr_load = start;
         ON: begin
            if (!abort) begin
               if (skip_now) begin
                  tmr_load = !last;
               end else if (tmr_expire) begin
                  tmr_load = 1'b1;
                  tmr_len  = OFF_LEN;
               end
            end
         end
         OFF:     tmr_load = !abort && tmr_expire && !last;
         default: tmr_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         sh_a  <= '0;
         sh_b  <= '0;
         sh_c  <= '0;
         sh_d  <= '0;
         {O1, O2, O3, O4} <= 4'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  sh_a  <= A;
                  sh_b  <= B;
                  sh_c  <= C;
                  sh_d  <= D;
                  idx   <= '0;
                  state <= ON;
                  busy  <= 1'b1;
                  {O1, O2, O3, O4} <= {A[0], B[0], C[0], D[0]};
               end
            end
            ON, OFF: begin
               if (abort) begin
                  state <= IDLE;
                  idx   <= '0;
                  busy  <= 1'b0;
                  {O1, O2, O3, O4} <= 4'b0;
               end else if ((state == ON && skip_now) || (state == OFF && tmr_expire)) begin
                  if (last) begin
                     state <= DONE;
                     idx   <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     {O1, O2, O3, O4} <= 4'b0;
                  end else begin
                     state <= ON;
                     idx   <= nxt;
                     {O1, O2, O3, O4} <= {sh_a[nxt], sh_b[nxt], sh_c[nxt], sh_d[nxt]};
                  end
               end else if (state == ON && tmr_expire) begin
                  state <= OFF;
                  {O1, O2, O3, O4} <= 4'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_player.sv
// Randomized and directed bench for sequence_player against a per-cycle reference trace.
module tb_sequence_player;
   import guess_pkg::*;

   localparam int STEPS = 7;
   localparam int ONC   = 2;
   localparam int OFFC  = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   code_t      A = '0, B = '0, C = '0, D = '0;
   logic       O1, O2, O3, O4, busy, done;
   logic [2:0] step;

   int checks = 0;
   int errors = 0;

   logic [5:0] exp_q[$];
   logic [2:0] stp_q[$];
   bit         chk_q[$];

   sequence_player #(.STEPS(STEPS), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .A(A), .B(B), .C(C), .D(D),
      .O1(O1), .O2(O2), .O3(O3), .O4(O4),
      .step(step), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Expected trace, one entry per cycle after start: {O1..O4, busy, done}.
   task automatic build_model(input code_t a, input code_t b, input code_t c, input code_t d);
      logic [3:0] bits;
      int on_n, off_n;
      exp_q.delete();
      stp_q.delete();
      chk_q.delete();
      for (int i = 0; i < STEPS; i++) begin
         bits  = {a[i], b[i], c[i], d[i]};
         on_n  = ONC;
         off_n = OFFC;
`ifdef SEQ_PLAYER_SKIP_EMPTY_EN
         if (bits == 4'b0) begin
            on_n  = 1;
            off_n = 0;
         end
`endif
         for (int k = 0; k < on_n; k++) begin
            exp_q.push_back({bits, 2'b10});
            stp_q.push_back(3'(i));
            chk_q.push_back(1'b1);
         end
         for (int k = 0; k < off_n; k++) begin
            exp_q.push_back(6'b000010);
            stp_q.push_back(3'(i));
            chk_q.push_back(1'b1);
         end
      end
      exp_q.push_back(6'b000001);
      stp_q.push_back(3'd0);
      chk_q.push_back(1'b0);
   endtask

   function automatic code_t rnd_code();
      logic [31:0] r;
      r = $urandom;
      return r[6:0];
   endfunction

   task automatic run_seq(input code_t a, input code_t b, input code_t c, input code_t d,
                          input int abort_cyc, input int restart_cyc, input bit mutate,
                          input bit abort_at_start, input string tag, output int done_cyc);
      int n;
      logic [5:0] got, exp;
      logic [2:0] sexp;
      bit chk;
      build_model(a, b, c, d);
      n = exp_q.size();
      A = a; B = b; C = c; D = d;
      start = 1'b1;
      abort = abort_at_start;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      done_cyc = -1;
      for (int cyc = 1; cyc <= n + 2; cyc++) begin
         if (abort_cyc > 0 && cyc > abort_cyc) begin
            exp = 6'b0; sexp = 3'd0; chk = 1'b1;
         end else if (cyc <= n) begin
            exp = exp_q[cyc-1]; sexp = stp_q[cyc-1]; chk = chk_q[cyc-1];
         end else begin
            exp = 6'b0; sexp = 3'd0; chk = 1'b1;
         end
         got = {O1, O2, O3, O4, busy, done};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d outputs{O1..O4,busy,done}=%b expected %b", tag, cyc, got, exp);
         end
         if (chk) begin
            checks++;
            if (step !== sexp) begin
               errors++;
               $display("FAIL %s cycle %0d step=%0d expected %0d", tag, cyc, step, sexp);
            end
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
         abort = (cyc == abort_cyc);
         start = (cyc == restart_cyc);
         if (mutate && cyc == 3) begin
            A = rnd_code(); B = rnd_code(); C = rnd_code(); D = rnd_code();
         end
         @(posedge clk); #1;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({O1, O2, O3, O4, busy, done, step} !== 9'b0) begin
         errors++;
         $display("FAIL reset_state outputs=%b expected 0", {O1, O2, O3, O4, busy, done, step});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({O1, O2, O3, O4, busy, done, step} !== 9'b0) begin
         errors++;
         $display("FAIL reset_idle outputs=%b expected 0", {O1, O2, O3, O4, busy, done, step});
      end
   endtask

   task automatic test_directed();
      int dc, want;
`ifdef SEQ_PLAYER_SKIP_EMPTY_EN
      want = 14;
`else
      want = 22;
`endif
      run_seq(7'b1000000, 7'b0, 7'b0010000, 7'b0001000, 0, 0, 0, 0, "scen1", dc);
      checks++;
      if (dc !== want) begin
         errors++;
         $display("FAIL scen1_done_cycle got %0d expected %0d", dc, want);
      end
      run_seq(7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 0, 0, 0, 0, "all_ones", dc);
      checks++;
      if (dc !== 22) begin
         errors++;
         $display("FAIL all_ones_done_cycle got %0d expected 22", dc);
      end
   endtask

   task automatic test_abort();
      int dc, n;
      code_t a, b, c, d;
      run_seq(7'b1000000, 7'b0, 7'b0010000, 7'b0001000, 5, 0, 0, 0, "abort5", dc);
      checks++;
      if (dc !== -1) begin
         errors++;
         $display("FAIL abort5_no_done done seen at cycle %0d expected none", dc);
      end
      run_seq(7'b1000000, 7'b0, 7'b0010000, 7'b0001000, 0, 0, 0, 0, "replay_after_abort", dc);
      for (int t = 0; t < 4; t++) begin
         a = rnd_code(); b = rnd_code(); c = rnd_code(); d = rnd_code();
         build_model(a, b, c, d);
         n = exp_q.size();
         run_seq(a, b, c, d, int'($urandom_range(1, n - 1)), 0, 0, 0, "abort_rand", dc);
      end
      // abort raised in the DONE cycle must not disturb completion
      build_model(7'b1010101, 7'b0, 7'b0, 7'b0100000);
      n = exp_q.size();
      run_seq(7'b1010101, 7'b0, 7'b0, 7'b0100000, n, 0, 0, 0, "abort_in_done", dc);
   endtask

   task automatic test_reset_mid();
      int dc;
      A = '1; B = '1; C = '1; D = '1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({O1, O2, O3, O4, busy} !== 5'b11111) begin
         errors++;
         $display("FAIL pre_reset_pulse outputs=%b expected 11111", {O1, O2, O3, O4, busy});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({O1, O2, O3, O4, busy, done, step} !== 9'b0) begin
         errors++;
         $display("FAIL async_reset outputs=%b expected 0", {O1, O2, O3, O4, busy, done, step});
      end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({O1, O2, O3, O4, busy, done, step} !== 9'b0) begin
         errors++;
         $display("FAIL post_reset_idle outputs=%b expected 0", {O1, O2, O3, O4, busy, done, step});
      end
      run_seq(7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 0, 0, 0, 0, "replay_after_reset", dc);
   endtask

   task automatic test_restart_ignored();
      int dc;
      run_seq(7'b1000000, 7'b0, 7'b0010000, 7'b0001000, 0, 3, 1, 0, "restart_ignored", dc);
      run_seq(7'b0110010, 7'b1000001, 7'b0, 7'b0011100, 0, 9, 1, 0, "restart_ignored2", dc);
   endtask

   task automatic test_start_abort_together();
      int dc;
      run_seq(7'b1100110, 7'b0010001, 7'b0, 7'b1000000, 0, 0, 0, 1, "start_with_abort", dc);
   endtask

   task automatic test_random();
      int dc;
      for (int t = 0; t < 6; t++)
         run_seq(rnd_code(), rnd_code(), rnd_code(), rnd_code(), 0, 0, 0, 0, "random", dc);
      run_seq(7'b0, 7'b0, 7'b0, 7'b0, 0, 0, 0, 0, "all_empty", dc);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_reset_mid();
      test_restart_ignored();
      test_start_abort_together();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
